exc_ctrl: RTL

//  Exception detect/prioritise unit at M stage, directly upstream of the CP0 register file. Merges per-instruction

---
 rtl/exc_ctrl_pkg.sv | 31 +++
 rtl/exc_ctrl_if.sv | 45 ++++
 rtl/exc_prio_enc.sv | 45 ++++
 rtl/exc_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared exception codes, FSM state encoding and the per-instruction flag bundle
// used by the M-stage exception controller.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT       = 5'h00;
    localparam logic [4:0] EXC_ADEL      = 5'h04;
    localparam logic [4:0] EXC_ADES      = 5'h05;
    localparam logic [4:0] EXC_SYS       = 5'h08;
    localparam logic [4:0] EXC_BP        = 5'h09;
    localparam logic [4:0] EXC_RI        = 5'h0a;
    localparam logic [4:0] EXC_OV        = 5'h0c;
    localparam logic [4:0] EXC_TYPE_ERET = 5'h0e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPORT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic adel_if;
        logic ri;
        logic ov;
        logic sys;
        logic bp;
        logic eret;
        logic adel_ld;
        logic ades_st;
    } exc_flags_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// M-stage / CP0 / pipeline-control signal bundle of the exception controller.
interface exc_ctrl_if;
    logic        m_valid;
    logic        m_stall;
    logic [31:0] m_pc;
    logic        m_indelayslot;
    logic [31:0] m_addr;
    logic        m_adel_if;
    logic        m_adel_ld;
    logic        m_ades_st;
    logic        m_ri;
    logic        m_ov;
    logic        m_sys;
    logic        m_bp;
    logic        m_eret;
    logic [5:0]  int_i;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic        m_kill;
    logic        exc_en;
    logic [4:0]  exc_type;
    logic [31:0] exc_pc;
    logic        exc_indelayslot;
    logic [31:0] exc_badvaddr;
    logic        flush_o;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport slave (
        input  m_valid, m_stall, m_pc, m_indelayslot, m_addr,
        input  m_adel_if, m_adel_ld, m_ades_st, m_ri, m_ov, m_sys, m_bp, m_eret,
        input  int_i, cp0_status, cp0_cause, cp0_epc,
        output m_kill, exc_en, exc_type, exc_pc, exc_indelayslot, exc_badvaddr,
        output flush_o, redirect_valid, redirect_pc
    );

    modport master (
        output m_valid, m_stall, m_pc, m_indelayslot, m_addr,
        output m_adel_if, m_adel_ld, m_ades_st, m_ri, m_ov, m_sys, m_bp, m_eret,
        output int_i, cp0_status, cp0_cause, cp0_epc,
        input  m_kill, exc_en, exc_type, exc_pc, exc_indelayslot, exc_badvaddr,
        input  flush_o, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks one exception code from the interrupt
// qualifier and instruction flags, and selects the matching bad virtual address.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic        int_ok,
    input  exc_flags_t  flags,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    output logic [4:0]  exc_type,
    output logic [31:0] badvaddr,
    output logic        is_eret
);

    always_comb begin
        exc_type = EXC_INT;
        badvaddr = '0;
        is_eret  = 1'b0;
        // Interrupts attach to the instruction and pre-empt all of its own faults.
        if (int_ok) begin
            exc_type = EXC_INT;
        end else if (flags.adel_if) begin
            exc_type = EXC_ADEL;
            badvaddr = pc;
        end else if (flags.ri) begin
            exc_type = EXC_RI;
        end else if (flags.ov) begin
            exc_type = EXC_OV;
        end else if (flags.sys) begin
            exc_type = EXC_SYS;
        end else if (flags.bp) begin
            exc_type = EXC_BP;
        end else if (flags.eret) begin
            exc_type = EXC_TYPE_ERET;
            is_eret  = 1'b1;
        end else if (flags.adel_ld) begin
            exc_type = EXC_ADEL;
            badvaddr = addr;
        end else if (flags.ades_st) begin
            exc_type = EXC_ADES;
            badvaddr = addr;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// M-stage exception controller: synchronises interrupts, detects and prioritises
// exceptions, registers the CP0 write and drives flush / PC redirect.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2
) (
    input logic       clk,
    input logic       rst,
    exc_ctrl_if.slave bus
);

    localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;

    logic [5:0]    int_s1_reg, int_sync_reg;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          exc_en_reg, redirect_valid_reg, flush_reg, indelayslot_reg;
    logic [4:0]    exc_type_reg;
    logic [31:0]   exc_pc_reg, badvaddr_reg, redirect_pc_reg;

    exc_flags_t    flags;
    logic          int_pend, int_ok, take, enc_is_eret;
    logic [4:0]    enc_type;
    logic [31:0]   enc_badvaddr;
    logic          unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_s1_reg   <= '0;
            int_sync_reg <= '0;
        end else begin
            int_s1_reg   <= bus.int_i;
            int_sync_reg <= int_s1_reg;
        end
    end

    assign int_pend = |({int_sync_reg, bus.cp0_cause[9:8]} & bus.cp0_status[15:8]);
    assign int_ok   = int_pend & bus.cp0_status[0] & ~bus.cp0_status[1];

    assign flags = '{adel_if: bus.m_adel_if, ri: bus.m_ri, ov: bus.m_ov, sys: bus.m_sys,
                     bp: bus.m_bp, eret: bus.m_eret, adel_ld: bus.m_adel_ld,
                     ades_st: bus.m_ades_st};

    assign take       = (state_reg == IDLE) & bus.m_valid & ~bus.m_stall & (int_ok | (|flags));
    assign bus.m_kill = take;

    exc_prio_enc u_prio (
        .int_ok   (int_ok),
        .flags    (flags),
        .pc       (bus.m_pc),
        .addr     (bus.m_addr),
        .exc_type (enc_type),
        .badvaddr (enc_badvaddr),
        .is_eret  (enc_is_eret)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE:   if (take) state_next = REPORT;
            REPORT: begin
                if (FLUSH_CYCLES > 1) begin
                    state_next = HOLD;
                    cnt_next   = CW'(FLUSH_CYCLES - 2);
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (cnt_reg == '0) state_next = IDLE;
                else               cnt_next   = cnt_reg - CW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= IDLE;
            cnt_reg            <= '0;
            exc_en_reg         <= 1'b0;
            redirect_valid_reg <= 1'b0;
            flush_reg          <= 1'b0;
            exc_type_reg       <= '0;
            exc_pc_reg         <= '0;
            indelayslot_reg    <= 1'b0;
            badvaddr_reg       <= '0;
            redirect_pc_reg    <= '0;
        end else begin
            state_reg          <= state_next;
            cnt_reg            <= cnt_next;
            exc_en_reg         <= take;
            redirect_valid_reg <= take;
            flush_reg          <= (state_next != IDLE);
            // Report fields hold their value until the next taken exception.
            if (take) begin
                exc_type_reg    <= enc_type;
                exc_pc_reg      <= bus.m_pc;
                indelayslot_reg <= bus.m_indelayslot & ~enc_is_eret;
                badvaddr_reg    <= enc_badvaddr;
                redirect_pc_reg <= enc_is_eret ? bus.cp0_epc : EXC_VECTOR;
            end
        end
    end

    assign bus.exc_en          = exc_en_reg;
    assign bus.redirect_valid  = redirect_valid_reg;
    assign bus.flush_o         = flush_reg;
    assign bus.exc_type        = exc_type_reg;
    assign bus.exc_pc          = exc_pc_reg;
    assign bus.exc_indelayslot = indelayslot_reg;
    assign bus.exc_badvaddr    = badvaddr_reg;
    assign bus.redirect_pc     = redirect_pc_reg;

    assign unused_bits = ^{bus.cp0_status[31:16], bus.cp0_status[7:2],
                           bus.cp0_cause[31:10], bus.cp0_cause[7:0]};

endmodule
